serdes_serializer: RTL and testbench
====================================

// Module: serdes_serializer
// PURPOSE
//   Transmit-side partner of the serdes deserializer. Accepts one frame of N_SAMPLES parallel
//   words on a val/rdy interface and emits it one word per handshake on a serial val/rdy
//   interface, word 0 first. Sits between a frame-producing block (e.g. FFT output) and a
//   word-wide link; serializer->deserializer back-to-back must reproduce the frame exactly.
// PARAMETERS
//   N_SAMPLES  8   words per frame; >=1, need not be a power of two
//   BIT_WIDTH  32  bits per word
// PORTS
//   clk       in   1                     clock; all state updates on posedge
//   reset     in   1                     reset, synchronous, active-high
//   recv_val  in   1                     parallel frame valid
//   recv_rdy  out  1                     block can accept a frame
//   recv_msg  in   BIT_WIDTH x N_SAMPLES unpacked frame, recv_msg[0] sent first
//   send_val  out  1                     serial word valid
//   send_rdy  in   1                     downstream accepts word
//   send_msg  out  BIT_WIDTH             current serial word
// BEHAVIOUR
//   - N_SAMPLES==1: pure wires: recv_rdy=send_rdy, send_val=recv_val, send_msg=recv_msg[0];
//     clk/reset unused (tie into an unused-signal sink). Everything below is for N_SAMPLES>=2.
//   - Storage: N_SAMPLES x BIT_WIDTH frame buffer, index counter cnt of $clog2(N_SAMPLES) bits,
//     1-bit state {IDLE, BUSY}. send_msg = buf[cnt] (registered data, combinational mux).
//   - Reset: state=IDLE, cnt=0, buffer cleared to 0 -> recv_rdy=1, send_val=0, send_msg=0.
//   - IDLE: recv_rdy=1, send_val=0. On recv_val&recv_rdy: load all words into buffer, cnt<=0,
//     state<=BUSY. recv_msg sampled only at that edge; later changes ignored.
//   - BUSY: send_val=1, send_msg=buf[cnt]. On send_rdy: if cnt!=N_SAMPLES-1, cnt<=cnt+1;
//     else (last word) cnt<=0 and state<=IDLE. No send_rdy: hold cnt, send_msg stable.
//   - Back-to-back: in BUSY with cnt==N_SAMPLES-1, recv_rdy=send_rdy (combinational). If last
//     word fires and recv_val=1 in the same cycle, new frame loads, cnt<=0, state stays BUSY:
//     zero bubble, throughput N_SAMPLES cycles/frame. Otherwise recv_rdy=0 in BUSY.
//   - cnt never exceeds N_SAMPLES-1; explicit clear at last word handles non-power-of-two N.
//   - Latency: first word valid the cycle after recv handshake.
//   - send_val once asserted is held until the word is accepted (no retraction).
//   - Reset mid-frame: remaining words discarded, outputs return to reset values next cycle.
// CONFIGURATION
//   SERDES_SERIALIZER_LAST_EN
//     defined: adds output port send_last (1 bit) = send_val & (cnt==N_SAMPLES-1), marking the
//       final word of each frame; 0 at reset. For N_SAMPLES==1, send_last = send_val.
//     undefined: port absent; behaviour otherwise identical.
// TESTING
//   1 N=4,W=8: reset -> recv_rdy=1, send_val=0, send_msg=0; frame {11,22,33,44}, send_rdy=1
//     -> send_msg 11,22,33,44 on cycles 1..4 after handshake, then send_val=0, recv_rdy=1.
//   2 Backpressure: N=4, send_rdy low 3 cycles on word 2 -> send_msg holds 33, send_val=1,
//     recv_rdy=0; release -> 33 then 44, no loss or duplication.
//   3 Back-to-back: recv_val held high, frames {1,2,3,4},{5,6,7,8}, send_rdy=1 -> 8 consecutive
//     valid words 1..8, no bubble; recv_rdy pulses only on last-word cycles.
//   4 N=5 (non-pow2): frame {A,B,C,D,E} -> exactly 5 words, cnt wraps 4->0, then IDLE.
//   5 Reset after 2 of 4 words sent -> next cycle send_val=0, recv_rdy=1; new frame
//     {9,8,7,6} emits from word 0.
//   6 Loopback into deserializer (N=8,W=32), 100 random frames, random send_rdy stalls ->
//     every received frame equals sent frame; LAST_EN build: send_last high only on word 7.

Source files
------------

// File: rtl/serdes_serializer.sv
// rtl/serdes_serializer.sv - frame-to-word serializer; SERDES_SERIALIZER_LAST_EN adds send_last
// Loads one N_SAMPLES-word frame and emits it word 0 first, one word per send handshake.
module serdes_serializer #(
  parameter int N_SAMPLES = 8,
  parameter int BIT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 recv_val,
  output logic                 recv_rdy,
  input  logic [BIT_WIDTH-1:0] recv_msg [N_SAMPLES],
  output logic                 send_val,
  input  logic                 send_rdy,
`ifdef SERDES_SERIALIZER_LAST_EN
  output logic                 send_last,
`endif
  output logic [BIT_WIDTH-1:0] send_msg
);

  generate
    if (N_SAMPLES == 1) begin : g_wire
      logic unused_clk_reset;
      assign unused_clk_reset = &{1'b0, clk, reset};
      assign recv_rdy = send_rdy;
      assign send_val = recv_val;
      assign send_msg = recv_msg[0];
`ifdef SERDES_SERIALIZER_LAST_EN
      assign send_last = recv_val;
`endif
    end else begin : g_ser
      localparam int CW = $clog2(N_SAMPLES);
      localparam logic [0:0] IDLE = 1'b0;
      localparam logic [0:0] BUSY = 1'b1;

      logic [0:0]           state;
      logic [CW-1:0]        cnt;
      logic [BIT_WIDTH-1:0] frame_buf [N_SAMPLES];
      logic                 at_last;
      logic                 load;

      assign at_last  = (cnt == CW'(N_SAMPLES - 1));
      // Accepting a new frame on the last word's handshake keeps the link bubble-free.
      assign recv_rdy = (state == IDLE) || (at_last && send_rdy);
      assign send_val = (state == BUSY);
      assign send_msg = frame_buf[cnt];
      assign load     = recv_val && recv_rdy;
`ifdef SERDES_SERIALIZER_LAST_EN
      assign send_last = send_val && at_last;
`endif

      always_ff @(posedge clk) begin
        if (reset) begin
          state <= IDLE;
          cnt   <= '0;
          for (int i = 0; i < N_SAMPLES; i++) frame_buf[i] <= '0;
        end else if (load) begin
          frame_buf <= recv_msg;
          cnt       <= '0;
          state     <= BUSY;
        end else if (state == BUSY && send_rdy) begin
          // Explicit clear at the last word keeps non-power-of-two frames in range.
          if (at_last) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_serdes_serializer.sv
// tb/tb_serdes_serializer.sv - directed and scoreboarded checks of serdes_serializer (N=4, N=5, N=1)
module tb_serdes_serializer;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic a_rv, a_rr, a_sv, a_sr, a_last;
  logic [7:0] a_m [4];
  logic [7:0] a_sm;
  logic b_rv, b_rr, b_sv, b_sr, b_last;
  logic [7:0] b_m [5];
  logic [7:0] b_sm;
  logic c_rv, c_rr, c_sv, c_sr, c_last;
  logic [7:0] c_m [1];
  logic [7:0] c_sm;

  int total = 0;
  int bad = 0;

  serdes_serializer #(.N_SAMPLES(4), .BIT_WIDTH(8)) dut_a (
    .clk(clk), .reset(reset), .recv_val(a_rv), .recv_rdy(a_rr), .recv_msg(a_m),
    .send_val(a_sv), .send_rdy(a_sr),
`ifdef SERDES_SERIALIZER_LAST_EN
    .send_last(a_last),
`endif
    .send_msg(a_sm));

  serdes_serializer #(.N_SAMPLES(5), .BIT_WIDTH(8)) dut_b (
    .clk(clk), .reset(reset), .recv_val(b_rv), .recv_rdy(b_rr), .recv_msg(b_m),
    .send_val(b_sv), .send_rdy(b_sr),
`ifdef SERDES_SERIALIZER_LAST_EN
    .send_last(b_last),
`endif
    .send_msg(b_sm));

  serdes_serializer #(.N_SAMPLES(1), .BIT_WIDTH(8)) dut_c (
    .clk(clk), .reset(reset), .recv_val(c_rv), .recv_rdy(c_rr), .recv_msg(c_m),
    .send_val(c_sv), .send_rdy(c_sr),
`ifdef SERDES_SERIALIZER_LAST_EN
    .send_last(c_last),
`endif
    .send_msg(c_sm));

`ifndef SERDES_SERIALIZER_LAST_EN
  assign a_last = 1'b0;
  assign b_last = 1'b0;
  assign c_last = 1'b0;
`endif

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input logic [7:0] w0, w1, w2, w3);
    a_m[0] = w0; a_m[1] = w1; a_m[2] = w2; a_m[3] = w3;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    a_rv = 0; a_sr = 0; b_rv = 0; b_sr = 0; c_rv = 0; c_sr = 0;
    set_a(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    for (int i = 0; i < 5; i++) b_m[i] = 8'hFF;
    c_m[0] = 8'h00;
    tick; tick;
    reset = 1'b0;
    #1;
    total++; if (a_rr !== 1'b1) begin bad++; $display("FAIL reset_recv_rdy got=%b exp=1", a_rr); end
    total++; if (a_sv !== 1'b0) begin bad++; $display("FAIL reset_send_val got=%b exp=0", a_sv); end
    total++; if (a_sm !== 8'h00) begin bad++; $display("FAIL reset_send_msg got=%0h exp=0", a_sm); end
    total++; if (b_sv !== 1'b0 || b_sm !== 8'h00) begin bad++; $display("FAIL reset_n5 got=%b/%0h exp=0/0", b_sv, b_sm); end
  endtask

  task automatic test_basic;
    logic [7:0] exp [4];
    exp = '{8'd11, 8'd22, 8'd33, 8'd44};
    set_a(8'd11, 8'd22, 8'd33, 8'd44);
    a_rv = 1; a_sr = 1;
    #1;
    total++; if (a_rr !== 1'b1) begin bad++; $display("FAIL basic_accept got=%b exp=1", a_rr); end
    tick;
    a_rv = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if (a_sv !== 1'b1) begin bad++; $display("FAIL basic_val%0d got=%b exp=1", i, a_sv); end
      total++; if (a_sm !== exp[i]) begin bad++; $display("FAIL basic_msg%0d got=%0d exp=%0d", i, a_sm, exp[i]); end
      total++; if (a_rr !== (i == 3)) begin bad++; $display("FAIL basic_rdy%0d got=%b exp=%b", i, a_rr, (i == 3)); end
`ifdef SERDES_SERIALIZER_LAST_EN
      total++; if (a_last !== (i == 3)) begin bad++; $display("FAIL basic_last%0d got=%b exp=%b", i, a_last, (i == 3)); end
`endif
      tick;
    end
    #1;
    total++; if (a_sv !== 1'b0 || a_rr !== 1'b1) begin bad++; $display("FAIL basic_idle got=%b/%b exp=0/1", a_sv, a_rr); end
  endtask

  task automatic test_backpressure;
    set_a(8'd11, 8'd22, 8'd33, 8'd44);
    a_rv = 1; a_sr = 1;
    tick;
    a_rv = 0;
    tick; tick;
    a_sr = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++; if (a_sv !== 1'b1 || a_sm !== 8'd33) begin bad++; $display("FAIL bp_hold%0d got=%b/%0d exp=1/33", k, a_sv, a_sm); end
      total++; if (a_rr !== 1'b0) begin bad++; $display("FAIL bp_rdy%0d got=%b exp=0", k, a_rr); end
      tick;
    end
    a_sr = 1;
    #1;
    total++; if (a_sm !== 8'd33) begin bad++; $display("FAIL bp_release got=%0d exp=33", a_sm); end
    tick; #1;
    total++; if (a_sm !== 8'd44 || a_rr !== 1'b1) begin bad++; $display("FAIL bp_last got=%0d/%b exp=44/1", a_sm, a_rr); end
    tick; #1;
    total++; if (a_sv !== 1'b0) begin bad++; $display("FAIL bp_idle got=%b exp=0", a_sv); end
  endtask

  task automatic test_back_to_back;
    set_a(8'd1, 8'd2, 8'd3, 8'd4);
    a_rv = 1; a_sr = 1;
    tick;
    set_a(8'd5, 8'd6, 8'd7, 8'd8);
    for (int i = 0; i < 8; i++) begin
      if (i == 4) a_rv = 0;
      #1;
      total++; if (a_sv !== 1'b1 || a_sm !== 8'(i + 1)) begin bad++; $display("FAIL b2b_word%0d got=%b/%0d exp=1/%0d", i, a_sv, a_sm, i + 1); end
      total++; if (a_rr !== (i % 4 == 3)) begin bad++; $display("FAIL b2b_rdy%0d got=%b exp=%b", i, a_rr, (i % 4 == 3)); end
      tick;
    end
    #1;
    total++; if (a_sv !== 1'b0) begin bad++; $display("FAIL b2b_idle got=%b exp=0", a_sv); end
  endtask

  task automatic test_nonpow2;
    for (int i = 0; i < 5; i++) b_m[i] = 8'(8'hA + i);
    b_rv = 1; b_sr = 1;
    tick;
    b_rv = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++; if (b_sv !== 1'b1 || b_sm !== 8'(8'hA + i)) begin bad++; $display("FAIL n5_word%0d got=%b/%0h exp=1/%0h", i, b_sv, b_sm, 8'hA + i); end
      total++; if (b_rr !== (i == 4)) begin bad++; $display("FAIL n5_rdy%0d got=%b exp=%b", i, b_rr, (i == 4)); end
`ifdef SERDES_SERIALIZER_LAST_EN
      total++; if (b_last !== (i == 4)) begin bad++; $display("FAIL n5_last%0d got=%b exp=%b", i, b_last, (i == 4)); end
`endif
      tick;
    end
    #1;
    total++; if (b_sv !== 1'b0 || b_rr !== 1'b1) begin bad++; $display("FAIL n5_idle got=%b/%b exp=0/1", b_sv, b_rr); end
    for (int i = 0; i < 5; i++) b_m[i] = 8'(8'h10 + i);
    b_rv = 1;
    tick;
    b_rv = 0;
    #1;
    total++; if (b_sm !== 8'h10) begin bad++; $display("FAIL n5_wrap got=%0h exp=10", b_sm); end
    for (int i = 0; i < 5; i++) tick;
  endtask

  task automatic test_reset_mid;
    logic [7:0] exp [4];
    exp = '{8'd9, 8'd8, 8'd7, 8'd6};
    set_a(8'd11, 8'd22, 8'd33, 8'd44);
    a_rv = 1; a_sr = 1;
    tick;
    a_rv = 0;
    tick; tick;
    reset = 1;
    tick;
    #1;
    total++; if (a_sv !== 1'b0 || a_rr !== 1'b1 || a_sm !== 8'h00) begin bad++; $display("FAIL midreset got=%b/%b/%0h exp=0/1/0", a_sv, a_rr, a_sm); end
    reset = 0;
    set_a(8'd9, 8'd8, 8'd7, 8'd6);
    a_rv = 1;
    tick;
    a_rv = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if (a_sv !== 1'b1 || a_sm !== exp[i]) begin bad++; $display("FAIL midreset_word%0d got=%b/%0d exp=1/%0d", i, a_sv, a_sm, exp[i]); end
      tick;
    end
  endtask

  task automatic test_wires;
    c_m[0] = 8'h5A; c_rv = 1; c_sr = 0;
    #1;
    total++; if (c_rr !== 1'b0 || c_sv !== 1'b1 || c_sm !== 8'h5A) begin bad++; $display("FAIL n1_pass got=%b/%b/%0h exp=0/1/5a", c_rr, c_sv, c_sm); end
`ifdef SERDES_SERIALIZER_LAST_EN
    total++; if (c_last !== 1'b1) begin bad++; $display("FAIL n1_last got=%b exp=1", c_last); end
`endif
    c_rv = 0; c_sr = 1;
    #1;
    total++; if (c_rr !== 1'b1 || c_sv !== 1'b0) begin bad++; $display("FAIL n1_idle got=%b/%b exp=1/0", c_rr, c_sv); end
  endtask

  task automatic test_random;
    logic [7:0] q [$];
    logic [7:0] held;
    logic [7:0] exp;
    logic stall;
    int frames, cyc, pos;
    frames = 0; cyc = 0; pos = 0; stall = 0; held = '0;
    while (frames < 100 && cyc < 4000) begin
      a_rv = 1'($urandom_range(0, 1));
      a_sr = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 4; i++) a_m[i] = 8'($urandom);
      #1;
      if (stall) begin
        total++; if (a_sv !== 1'b1 || a_sm !== held) begin bad++; $display("FAIL rnd_hold got=%b/%0h exp=1/%0h", a_sv, a_sm, held); end
      end
`ifdef SERDES_SERIALIZER_LAST_EN
      if (a_sv) begin
        total++; if (a_last !== (pos == 3)) begin bad++; $display("FAIL rnd_last got=%b exp=%b", a_last, (pos == 3)); end
      end
`endif
      if (a_rv && a_rr) begin
        for (int i = 0; i < 4; i++) q.push_back(a_m[i]);
        frames++;
      end
      if (a_sv && a_sr) begin
        exp = q.pop_front();
        total++; if (a_sm !== exp) begin bad++; $display("FAIL rnd_word got=%0h exp=%0h", a_sm, exp); end
        pos = (pos + 1) % 4;
      end
      stall = a_sv && !a_sr;
      held = a_sm;
      tick;
      cyc++;
    end
    total++; if (frames != 100) begin bad++; $display("FAIL rnd_timeout got=%0d exp=100", frames); end
    a_rv = 0; a_sr = 1; cyc = 0;
    while (q.size() > 0 && cyc < 50) begin
      #1;
      exp = q.pop_front();
      total++; if (a_sv !== 1'b1 || a_sm !== exp) begin bad++; $display("FAIL rnd_drain got=%b/%0h exp=1/%0h", a_sv, a_sm, exp); end
      tick;
      cyc++;
    end
    #1;
    total++; if (a_sv !== 1'b0 || q.size() != 0) begin bad++; $display("FAIL rnd_end got=%b/%0d exp=0/0", a_sv, q.size()); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_backpressure;
    test_back_to_back;
    test_nonpow2;
    test_reset_mid;
    test_wires;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
